dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port dmem (12-bit address, 32-bit data, registered syncram read) between two requesters.
- Requester 0 is the processor load/store path; requester 1 is a loader/debug master.
- Round-robin arbitration with a one-transaction-per-cycle req/gnt handshake.
- Tracks in-flight reads and returns each read's data to the requester that issued it.

Parameters:
ADDR_W, 12, dmem address width
DATA_W, 32, dmem data width
RD_LAT, 1, cycles from the address-sampling clock edge to valid q_dmem (range 1..4)

Ports:
clock  in  1  single clock for all state
reset  in  1  synchronous, active-high reset
m0_req  in  1  requester 0 transaction request
m0_wren  in  1  requester 0 write (1) / read (0)
m0_addr  in  ADDR_W  requester 0 address
m0_wdata  in  DATA_W  requester 0 write data
m0_gnt  out  1  requester 0 transaction accepted this cycle
m0_rvalid  out  1  requester 0 read data valid
m0_rdata  out  DATA_W  requester 0 read data
m1_req, m1_wren, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for requester 1
address_dmem  out  ADDR_W  dmem address
data  out  DATA_W  dmem write data
wren  out  1  dmem write enable
q_dmem  in  DATA_W  dmem read data

Behaviour:
- Interface (already decided): one clock `clock`; `reset` is synchronous and active-high.
- Reset:
  - rr_ptr=0, so requester 0 is favoured first.
  - Read-tag pipeline cleared.
  - Resulting outputs: all gnt=0, wren=0, address_dmem=0, data=0, all rvalid=0, all rdata=0.
- Reset mid-operation: in-flight reads are discarded; no rvalid is produced for them after reset.
- Handshake:
  - A requester holds req, wren, addr and wdata stable until it sees gnt=1.
  - A transaction is accepted in the cycle where req & gnt; the requester may change fields on the next cycle.
- Grant logic is combinational from req and rr_ptr:
  - Only one req high: that requester is granted, whatever rr_ptr says.
  - Both req high: requester rr_ptr is granted.
  - Neither req high: no grant.
  - At most one gnt is high per cycle.
- rr_ptr register: after any accepted transaction, rr_ptr <= ~winner. It is unchanged on idle cycles.
- dmem drive (combinational, same cycle as gnt):
  - address_dmem = winner addr; data = winner wdata; wren = winner wren.
  - With no grant: address_dmem=0, data=0, wren=0.
- Write: completes at the grant edge; no response.
- Read tracking:
  - Each accepted read pushes {valid=1, owner} into a shift pipeline of depth RD_LAT; idle cycles and writes push valid=0.
  - When the pipeline output is valid, m<owner>_rvalid=1 and m<owner>_rdata=q_dmem.
  - Otherwise rvalid=0 and rdata=0 (rdata is gated to zero).
  - Read data appears RD_LAT cycles after the grant cycle.
- Back-to-back reads from alternating owners return in issue order, one per cycle.
- Simultaneous events:
  - A new grant and a read return for either requester may occur in the same cycle.
  - Both rvalid outputs are never high together.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1; worst-case wait is 1 cycle.

Optional Feature:
DMEM_ARB_LOCK_EN
- With the macro: adds input ports m0_lock and m1_lock (1 bit each).
  - When the last winner has req=1 and lock=1, it is granted again regardless of rr_ptr, and rr_ptr is not updated.
  - Ownership is released on the first cycle the owner's lock=0 or req=0; normal round-robin resumes from rr_ptr = ~owner.
  - Used for atomic read-modify-write bursts.
  - lock from the non-owner is ignored.
- Without the macro: the lock ports do not exist; pure round-robin.

Test Plan:
1. Reset held 2 cycles with m0_req=m1_req=1 → all gnt=0, wren=0, address_dmem=0, rvalid=0. After release, first grant goes to m0.
2. m0 write addr 0x005, wdata 0xDEADBEEF; next cycle m0 read 0x005 → gnt each cycle, wren=1 then 0. After RD_LAT=1, m0_rvalid=1, m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
3. Both requesters read continuously (m0 addr 0x010, m1 addr 0x020, preloaded 0x11 and 0x22) → gnt alternates m0,m1,m0. Returns alternate m0_rdata=0x11 and m1_rdata=0x22, in order.
4. Only m1_req=1 while rr_ptr=0 → m1 granted immediately; rr_ptr becomes 0. A later simultaneous request → m0 granted.
5. Issue an m1 read to 0x030, then assert reset in the following cycle (RD_LAT=2) → no m1_rvalid is ever produced; outputs are at reset values.
6. With DMEM_ARB_LOCK_EN: m0 req+lock for 3 cycles while m1_req=1 → m0 granted 3 consecutive cycles. m0 drops lock → m1 granted next cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-requester round-robin arbiter for the single-port dmem, with read-owner tracking.
// Define DMEM_ARB_LOCK_EN to add m0_lock/m1_lock for atomic burst ownership.
module dmem_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wren,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              m0_lock,
`endif
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wren,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  logic              rr_ptr;
  logic              win;
  logic              any;
  logic              locked;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_o;
  logic              rv;
  logic              ro;

`ifdef DMEM_ARB_LOCK_EN
  logic held;
  logic owner;

  // Ownership persists only while the owner keeps both req and lock high
  always_comb begin
    locked = 1'b0;
    if (held) begin
      locked = owner ? (m1_req & m1_lock) : (m0_req & m0_lock);
    end
  end
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    any = !reset && (m0_req || m1_req);
    win = 1'b0;
    if (locked) begin
`ifdef DMEM_ARB_LOCK_EN
      win = owner;
`endif
    end else if (m0_req && m1_req) begin
      win = rr_ptr;
    end else begin
      win = m1_req;
    end
  end

  assign m0_gnt = any && !win;
  assign m1_gnt = any && win;

  always_comb begin
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    if (m0_gnt) begin
      address_dmem = m0_addr;
      data         = m0_wdata;
      wren         = m0_wren;
    end else if (m1_gnt) begin
      address_dmem = m1_addr;
      data         = m1_wdata;
      wren         = m1_wren;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (any && !locked) begin
      rr_ptr <= ~win;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      held  <= 1'b0;
      owner <= 1'b0;
    end else if (any) begin
      owner <= win;
      held  <= win ? m1_lock : m0_lock;
    end else begin
      held <= 1'b0;
    end
  end
`endif

  // Owner tag travels alongside the syncram read latency
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v[0] <= any && !wren;
      tag_o[0] <= win;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
    end
  end

  assign rv = tag_v[RD_LAT-1] && !reset;
  assign ro = tag_o[RD_LAT-1];

  assign m0_rvalid = rv && !ro;
  assign m1_rvalid = rv && ro;
  assign m0_rdata  = m0_rvalid ? q_dmem : '0;
  assign m1_rdata  = m1_rvalid ? q_dmem : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a syncram model and read scoreboard.
// Define DMEM_ARB_LOCK_EN to also exercise the lock burst.
module tb_dmem_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              m0_req, m0_wren, m1_req, m1_wren;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;
`ifdef DMEM_ARB_LOCK_EN
  logic              m0_lock = 1'b0;
  logic              m1_lock = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W:0] sb[$];

  always #5 clock = ~clock;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_wren(m0_wren), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .m0_lock(m0_lock),
`endif
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wren(m1_wren), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  // Syncram model: RD_LAT edges from address to data
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] qp  [0:RD_LAT-1];
  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    for (int i = 0; i < RD_LAT; i++) qp[i] = '0;
  end
  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= data;
    qp[0] <= mem[address_dmem];
    for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
  end
  assign q_dmem = qp[RD_LAT-1];

  task automatic check(input string name, input logic [DATA_W:0] got,
                       input logic [DATA_W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every returned read must match the oldest expected entry
  always @(negedge clock) begin
    if (m0_rvalid || m1_rvalid) begin
      check("rvalid_excl", {32'd0, m0_rvalid & m1_rvalid}, '0);
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {m1_rvalid, m1_rvalid ? m1_rdata : m0_rdata}, '1);
      end else begin
        logic [DATA_W:0] e;
        e = sb.pop_front();
        check("rvalid_owner", {32'd0, m1_rvalid}, {32'd0, e[DATA_W]});
        check("rdata", {1'b0, m1_rvalid ? m1_rdata : m0_rdata}, {1'b0, e[DATA_W-1:0]});
      end
    end
  end

  task automatic sample(input logic e0, input logic e1,
                        input logic [DATA_W-1:0] x, input bit push);
    @(negedge clock);
    check("m0_gnt", {32'd0, m0_gnt}, {32'd0, e0});
    check("m1_gnt", {32'd0, m1_gnt}, {32'd0, e1});
    if (push && e0 && !m0_wren) sb.push_back({1'b0, x});
    if (push && e1 && !m1_wren) sb.push_back({1'b1, x});
  endtask

  task automatic bus(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic w);
    check("address_dmem", {21'd0, a}, {21'd0, address_dmem});
    check("data", {1'b0, data}, {1'b0, d});
    check("wren", {32'd0, wren}, {32'd0, w});
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_outs();
    check("rst_m0_gnt", {32'd0, m0_gnt}, '0);
    check("rst_m1_gnt", {32'd0, m1_gnt}, '0);
    bus('0, '0, 1'b0);
    check("rst_m0_rvalid", {32'd0, m0_rvalid}, '0);
    check("rst_m1_rvalid", {32'd0, m1_rvalid}, '0);
    check("rst_rdata", {1'b0, m0_rdata | m1_rdata}, '0);
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b1; m0_wren = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b1; m1_wren = 1'b0; m1_addr = '0; m1_wdata = '0;
    repeat (2) begin
      @(negedge clock);
      reset_outs();
    end
    adv();
    reset = 1'b0;

    // Release with both requesting: m0 first, then m1
    sample(1, 0, 32'h0, 1);
    adv(); m0_req = 1'b0;
    sample(0, 1, 32'h0, 1);
    adv(); m1_req = 1'b0;

    // m0 write then read back
    m0_req = 1'b1; m0_wren = 1'b1; m0_addr = 12'h005; m0_wdata = 32'hDEADBEEF;
    sample(1, 0, 32'h0, 1);
    bus(12'h005, 32'hDEADBEEF, 1'b1);
    adv(); m0_wren = 1'b0; m0_wdata = '0;
    sample(1, 0, 32'hDEADBEEF, 1);
    bus(12'h005, 32'h0, 1'b0);
    adv(); m0_req = 1'b0;

    // Loader preloads two words
    m1_req = 1'b1; m1_wren = 1'b1; m1_addr = 12'h020; m1_wdata = 32'h22;
    sample(0, 1, 32'h0, 1);
    adv(); m1_addr = 12'h010; m1_wdata = 32'h11;
    sample(0, 1, 32'h0, 1);
    adv(); m1_req = 1'b0; m1_wren = 1'b0; m1_wdata = '0;

    // Idle cycle: no grant, bus at zero
    sample(0, 0, 32'h0, 1);
    bus('0, '0, 1'b0);
    adv();

    // Continuous reads from both: strict alternation, in-order returns
    m0_req = 1'b1; m0_addr = 12'h010;
    m1_req = 1'b1; m1_addr = 12'h020;
    for (int i = 0; i < 2; i++) begin
      sample(1, 0, 32'h11, 1);
      bus(12'h010, 32'h0, 1'b0);
      adv();
      sample(0, 1, 32'h22, 1);
      bus(12'h020, 32'h0, 1'b0);
      adv();
    end

    // Lone m1 wins with rr_ptr=0, pointer goes back to m0
    m0_req = 1'b0;
    sample(0, 1, 32'h22, 1);
    adv(); m0_req = 1'b1;
    sample(1, 0, 32'h11, 1);
    adv();
    sample(0, 1, 32'h22, 1);
    adv(); m0_req = 1'b0; m1_req = 1'b0;
    repeat (RD_LAT + 1) adv();

    // In-flight m1 read killed by reset
    m1_req = 1'b1; m1_addr = 12'h030;
    sample(0, 1, 32'h0, 0);
    adv(); m1_req = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset_outs();
    adv(); reset = 1'b0;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      @(negedge clock);
      check("no_rvalid_after_reset", {31'd0, m0_rvalid, m1_rvalid}, '0);
      adv();
    end

`ifdef DMEM_ARB_LOCK_EN
    // m0 holds the port for three cycles, then m1 gets it
    m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 12'h010;
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 12'h020;
    for (int i = 0; i < 3; i++) begin
      sample(1, 0, 32'h11, 1);
      adv();
    end
    m0_lock = 1'b0; m1_lock = 1'b0;
    sample(0, 1, 32'h22, 1);
    adv(); m0_req = 1'b0; m1_req = 1'b0;
`endif

    repeat (RD_LAT + 3) adv();
    check("scoreboard_drained", {1'b0, 32'(sb.size())}, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
